// File: rtl/me_pkg.sv
// me_pkg: shared types and default sizes for the motion-estimation load
// sequencer.
//   me_load_state_t : controller states
//   *_DEF constants : default widths/sizes used as parameter defaults
package me_pkg;

  localparam int DATA_W_DEF    = 64;
  localparam int R_W_DEF       = 4;
  localparam int CUR_WORDS_DEF = 32;
  localparam int REF_WORDS_DEF = 128;
  localparam int TIMEOUT_DEF   = 4096;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_CUR = 3'd1,
    ST_LOAD_REF = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT     = 3'd4,
    ST_DONE     = 3'd5
  } me_load_state_t;

endpackage

// File: rtl/me_load_ctrl_if.sv
// me_load_ctrl_if: 64-bit valid/ready word stream feeding the load sequencer.
//   in_valid : source has a word
//   in_data  : the word
//   in_ready : sink accepts the word this cycle
// Modports: master = stream source, slave = the controller.
interface me_load_ctrl_if
  import me_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/me_wr_port.sv
// me_wr_port: registered write stage for one engine memory.
//   clk, rst_n     : clock, asynchronous active-low reset
//   wr_req         : write this cycle's address/data (strobe follows next cycle)
//   wr_addr/wr_data: address and data to register
//   address_write, data_write, write_enable : registered memory write port
// Address/data hold their last value between strobes; the strobe lasts
// exactly one cycle per request.
module me_wr_port #(
  parameter int AW = 5,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] address_write,
  output logic [DW-1:0] data_write,
  output logic          write_enable
);

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    we_d   = wr_req;
    if (wr_req) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign address_write = addr_q;
  assign data_write    = data_q;
  assign write_enable  = we_q;

endmodule

// File: rtl/me_load_ctrl.sv
// me_load_ctrl: sequencer in front of the motion-estimation engine.
// Fills the current-block memory, then (unless a held reference window is
// reused) the reference-window memory, pulses the engine start and waits for
// completion with a timeout.
//   clk, reset           : clock, asynchronous active-low reset
//   go, cfg_r, reuse_ref : job request and its settings (sampled in IDLE)
//   abort                : return to IDLE from any busy state
//   in_if (slave)        : 64-bit valid/ready word stream
//   *_write_cur/_ref     : registered memory write ports
//   r, me_start, me_done : engine interface
//   busy, done, timeout_err : status
module me_load_ctrl
  import me_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CUR_AW    = 5,
  parameter int REF_AW    = 7,
  parameter int CUR_WORDS = CUR_WORDS_DEF,
  parameter int REF_WORDS = REF_WORDS_DEF,
  parameter int R_W       = R_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [R_W-1:0]    cfg_r,
  input  logic              reuse_ref,
  input  logic              abort,
  me_load_ctrl_if.slave     in_if,
  output logic [CUR_AW-1:0] address_write_cur,
  output logic [DATA_W-1:0] data_write_cur,
  output logic              write_enable_cur,
  output logic [REF_AW-1:0] address_write_ref,
  output logic [DATA_W-1:0] data_write_ref,
  output logic              write_enable_ref,
  output logic [R_W-1:0]    r,
  output logic              me_start,
  input  logic              me_done,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CUR_AW-1:0] CUR_LAST = CUR_AW'(CUR_WORDS - 1);
  localparam logic [REF_AW-1:0] REF_LAST = REF_AW'(REF_WORDS - 1);
  // Compared against the count before increment, so WAIT lasts at most
  // TIMEOUT-1 cycles and the error shows TIMEOUT cycles after me_start.
  localparam logic [TW-1:0]     WAIT_LAST = TW'(TIMEOUT - 2);

  me_load_state_t    state_q, state_d;
  logic [CUR_AW-1:0] cur_cnt_q, cur_cnt_d;
  logic [REF_AW-1:0] ref_cnt_q, ref_cnt_d;
  logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [R_W-1:0]    cfg_q, cfg_d;
  logic              reuse_q, reuse_d;
  logic              ref_valid_q, ref_valid_d;
  logic              err_q, err_d;

  logic accept;
  logic cur_wr;
  logic ref_wr;
  logic start_c;
  logic done_c;

  assign in_if.in_ready = (state_q == ST_LOAD_CUR) || (state_q == ST_LOAD_REF);
  assign accept         = in_if.in_valid & in_if.in_ready;

  always_comb begin
    state_d     = state_q;
    cur_cnt_d   = cur_cnt_q;
    ref_cnt_d   = ref_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cfg_d       = cfg_q;
    reuse_d     = reuse_q;
    ref_valid_d = ref_valid_q;
    err_d       = err_q;
    cur_wr      = 1'b0;
    ref_wr      = 1'b0;
    start_c     = 1'b0;
    done_c      = 1'b0;

    if (abort) begin
      // Abort beats every transition, including a go seen in IDLE. Any word
      // presented this cycle is dropped; ref_valid is already 0 in LOAD_REF.
      state_d    = ST_IDLE;
      cur_cnt_d  = '0;
      ref_cnt_d  = '0;
      wait_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            cfg_d     = cfg_r;
            reuse_d   = reuse_ref;
            err_d     = 1'b0;
            cur_cnt_d = '0;
            ref_cnt_d = '0;
            state_d   = ST_LOAD_CUR;
          end
        end
        ST_LOAD_CUR: begin
          if (accept) begin
            cur_wr = 1'b1;
            if (cur_cnt_q == CUR_LAST) begin
              cur_cnt_d = '0;
              if (reuse_q && ref_valid_q) begin
                state_d = ST_START;
              end else begin
                ref_valid_d = 1'b0;
                state_d     = ST_LOAD_REF;
              end
            end else begin
              cur_cnt_d = cur_cnt_q + 1'b1;
            end
          end
        end
        ST_LOAD_REF: begin
          if (accept) begin
            ref_wr = 1'b1;
            if (ref_cnt_q == REF_LAST) begin
              ref_cnt_d   = '0;
              ref_valid_d = 1'b1;
              state_d     = ST_START;
            end else begin
              ref_cnt_d = ref_cnt_q + 1'b1;
            end
          end
        end
        ST_START: begin
          start_c    = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          // me_done is checked first so it wins over a coincident timeout.
          if (me_done) begin
            state_d = ST_DONE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cur_cnt_q   <= '0;
      ref_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      cfg_q       <= '0;
      reuse_q     <= 1'b0;
      ref_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_cnt_q   <= cur_cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      cfg_q       <= cfg_d;
      reuse_q     <= reuse_d;
      ref_valid_q <= ref_valid_d;
      err_q       <= err_d;
    end
  end

  me_wr_port #(.AW(CUR_AW), .DW(DATA_W)) u_wr_cur (
    .clk           (clk),
    .rst_n         (reset),
    .wr_req        (cur_wr),
    .wr_addr       (cur_cnt_q),
    .wr_data       (in_if.in_data),
    .address_write (address_write_cur),
    .data_write    (data_write_cur),
    .write_enable  (write_enable_cur)
  );

  me_wr_port #(.AW(REF_AW), .DW(DATA_W)) u_wr_ref (
    .clk           (clk),
    .rst_n         (reset),
    .wr_req        (ref_wr),
    .wr_addr       (ref_cnt_q),
    .wr_data       (in_if.in_data),
    .address_write (address_write_ref),
    .data_write    (data_write_ref),
    .write_enable  (write_enable_ref)
  );

  // r carries the range latched at the last accepted go.
  assign r           = cfg_q;
  assign me_start    = start_c;
  assign done        = done_c;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_me_load_ctrl.sv
// tb_me_load_ctrl: randomized bench for me_load_ctrl with a job-level model.
// The model tracks words still owed by the stream, which memory each accepted
// word belongs to, and the cycle numbers at which me_start / done must appear.
module tb_me_load_ctrl;
  import me_pkg::*;

  localparam int TO    = 16;
  localparam int NCUR  = 32;
  localparam int NREF  = 128;
  localparam int LIMIT = 3000;

  typedef struct {
    int          addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [3:0]  cfg_r = '0;
  logic        reuse_ref = 1'b0;
  logic        abort = 1'b0;
  logic        me_done = 1'b0;
  logic [4:0]  address_write_cur;
  logic [63:0] data_write_cur;
  logic        write_enable_cur;
  logic [6:0]  address_write_ref;
  logic [63:0] data_write_ref;
  logic        write_enable_ref;
  logic [3:0]  r;
  logic        me_start, busy, done, timeout_err;

  me_load_ctrl_if #(.DATA_W(64)) sif ();

  me_load_ctrl #(
    .DATA_W(64), .CUR_AW(5), .REF_AW(7), .CUR_WORDS(NCUR),
    .REF_WORDS(NREF), .R_W(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(rst_n), .go(go), .cfg_r(cfg_r), .reuse_ref(reuse_ref),
    .abort(abort), .in_if(sif),
    .address_write_cur(address_write_cur), .data_write_cur(data_write_cur),
    .write_enable_cur(write_enable_cur),
    .address_write_ref(address_write_ref), .data_write_ref(data_write_ref),
    .write_enable_ref(write_enable_ref),
    .r(r), .me_start(me_start), .me_done(me_done), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state.
  bit          m_active = 0, m_ref_valid = 0, m_reload = 0, m_err = 0;
  int          m_left = 0, m_taken = 0;
  int          m_start_cyc = -1, m_done_cyc = -1;
  logic [3:0]  m_cfg = '0;
  wr_t         cur_q[$];
  wr_t         ref_q[$];
  logic [63:0] words[NCUR+NREF];

  // Per-job observations made by the compare process.
  int          n_cur, n_ref, n_start, n_done;
  int          start_seen, done_seen, err_rise, last_cur_cyc;
  int          last_cur_addr, last_ref_addr;
  logic [63:0] last_cur_data, last_ref_data;
  bit          err_prev = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_left = 0; m_taken = 0; m_ref_valid = 0; m_err = 0;
    m_start_cyc = -1; m_done_cyc = -1; m_cfg = '0;
    cur_q.delete(); ref_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_step();
    int  p;
    wr_t e;
    p = cyc;
    cyc++;
    if (!rst_n) return;
    if (abort) begin
      if (m_active) begin
        m_active = 0; m_left = 0; m_start_cyc = -1; m_done_cyc = -1;
      end
      return;
    end
    if (!m_active) begin
      if (go) begin
        m_active = 1; m_cfg = cfg_r; m_err = 0; m_taken = 0;
        m_reload = !(reuse_ref && m_ref_valid);
        m_left   = NCUR + (m_reload ? NREF : 0);
      end
      return;
    end
    if (p == m_done_cyc) begin
      m_active = 0; m_start_cyc = -1; m_done_cyc = -1;
      return;
    end
    if (m_left > 0) begin
      if (sif.in_valid) begin
        e.data = sif.in_data;
        if (m_taken < NCUR) begin
          e.addr = m_taken;
          cur_q.push_back(e);
        end else begin
          e.addr = m_taken - NCUR;
          ref_q.push_back(e);
        end
        m_taken++;
        m_left--;
        if (m_taken == NCUR && m_left > 0) m_ref_valid = 0;
        if (m_left == 0) begin
          m_start_cyc = cyc;
          if (m_reload) m_ref_valid = 1;
        end
      end
      return;
    end
    // Engine wait: at most TO-1 cycles after me_start; me_done wins a tie.
    if (m_start_cyc >= 0 && m_done_cyc < 0 && p > m_start_cyc) begin
      if (me_done) begin
        m_done_cyc = cyc;
      end else if (p == m_start_cyc + TO - 1) begin
        m_done_cyc = cyc;
        m_err = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      check("busy", busy, m_active);
      check("in_ready", sif.in_ready, m_left > 0);
      check("me_start", me_start, cyc == m_start_cyc);
      check("done", done, cyc == m_done_cyc);
      check("timeout_err", timeout_err, m_err);
      if (write_enable_cur) begin
        if (cur_q.size() == 0) check("cur_unexpected_write", write_enable_cur, 1'b0);
        else begin
          e = cur_q.pop_front();
          check("cur_addr", address_write_cur, e.addr);
          check("cur_data", data_write_cur, e.data);
        end
        n_cur++; last_cur_cyc = cyc;
        last_cur_addr = address_write_cur; last_cur_data = data_write_cur;
      end
      if (write_enable_ref) begin
        if (ref_q.size() == 0) check("ref_unexpected_write", write_enable_ref, 1'b0);
        else begin
          e = ref_q.pop_front();
          check("ref_addr", address_write_ref, e.addr);
          check("ref_data", data_write_ref, e.data);
        end
        n_ref++;
        last_ref_addr = address_write_ref; last_ref_data = data_write_ref;
      end
      if (me_start) begin
        check("r_at_start", r, m_cfg);
        check("writes_pending_at_start", cur_q.size() + ref_q.size(), 0);
        n_start++; start_seen = cyc;
      end
      if (done) begin
        n_done++; done_seen = cyc;
      end
      if (timeout_err && !err_prev) err_rise = cyc;
      err_prev = timeout_err;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, sif.in_ready, 0);
    check({tag, "_me_start"}, me_start, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_r"}, r, 0);
    check({tag, "_we_cur"}, write_enable_cur, 0);
    check({tag, "_we_ref"}, write_enable_ref, 0);
    check({tag, "_addr_cur"}, address_write_cur, 0);
    check({tag, "_data_cur"}, data_write_cur, 0);
    check({tag, "_addr_ref"}, address_write_ref, 0);
    check({tag, "_data_ref"}, data_write_ref, 0);
  endtask

  // vmode: 0 = valid every cycle, 1 = toggle 1/0, 2 = random.
  // done_k: me_done pulse k cycles after me_start (large = never).
  // abort_at: abort when this many words have been accepted (-1 = never).
  // rst_k: drop reset mid-cycle k cycles after me_start (-1 = never).
  task automatic run_job(input logic [3:0] cfg, input bit reuse, input int vmode,
                         input int done_k, input int abort_at, input int rst_k,
                         input bit seq);
    int bound;
    bit did_rst;
    for (int i = 0; i < NCUR + NREF; i++)
      words[i] = seq ? 64'(i) : {$urandom, $urandom};
    n_cur = 0; n_ref = 0; n_start = 0; n_done = 0;
    start_seen = -1; done_seen = -1; err_rise = -1; last_cur_cyc = -1;
    go = 1'b1; cfg_r = cfg; reuse_ref = reuse;
    step();
    go = 1'b0;
    bound = 0;
    did_rst = 0;
    while (m_active && bound < LIMIT) begin
      if (rst_k >= 0 && m_start_cyc >= 0 && cyc == m_start_cyc + rst_k) begin
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_rst");
        model_reset();
        did_rst = 1;
        break;
      end
      cfg_r     = 4'($urandom);
      reuse_ref = 1'($urandom);
      go        = ($urandom_range(3) == 0);
      abort     = (abort_at >= 0 && m_left > 0 && m_taken == abort_at);
      case (vmode)
        0:       sif.in_valid = (m_left > 0) && !abort;
        1:       sif.in_valid = (m_left > 0) && !abort && (cyc % 2 == 0);
        default: sif.in_valid = (m_left > 0) && !abort && ($urandom_range(9) < 7);
      endcase
      sif.in_data = (m_left > 0) ? words[m_taken] : {$urandom, $urandom};
      me_done = (m_start_cyc >= 0) ? (cyc == m_start_cyc + done_k)
                                   : ($urandom_range(7) == 0);
      step();
      bound++;
    end
    if (bound >= LIMIT) check("job_cycle_budget", busy, 1'b0);
    go = 1'b0; abort = 1'b0; me_done = 1'b0; sif.in_valid = 1'b0;
    step();
    if (did_rst) rst_n = 1'b1;
    step();
    check("cur_writes_drained", cur_q.size(), 0);
    check("ref_writes_drained", ref_q.size(), 0);
    $display("job cfg=%0d reuse=%0d vmode=%0d done_k=%0d abort_at=%0d rst_k=%0d: cur=%0d ref=%0d start=%0d done=%0d err=%0b",
             cfg, reuse, vmode, done_k, abort_at, rst_k, n_cur, n_ref, n_start, n_done, timeout_err);
  endtask

  initial begin
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // Full load with sequential data 0..159.
    run_job(4'd3, 1'b0, 0, 10, -1, -1, 1'b1);
    check("A_cur_count", n_cur, NCUR);
    check("A_ref_count", n_ref, NREF);
    check("A_last_cur_addr", last_cur_addr, 31);
    check("A_last_cur_data", last_cur_data, 64'd31);
    check("A_last_ref_addr", last_ref_addr, 127);
    check("A_last_ref_data", last_ref_data, 64'd159);
    check("A_start_count", n_start, 1);
    check("A_done_count", n_done, 1);
    check("A_done_latency", done_seen - start_seen, 11);
    check("A_busy_after", busy, 0);

    // Reuse the held reference window.
    run_job(4'd5, 1'b1, 0, 3, -1, -1, 1'b0);
    check("B_ref_count", n_ref, 0);
    check("B_cur_count", n_cur, NCUR);
    check("B_start_with_last_cur", start_seen, last_cur_cyc);

    // Stalled stream during the current-block load.
    run_job(4'd7, 1'b1, 1, 4, -1, -1, 1'b0);
    check("C_cur_count", n_cur, NCUR);
    check("C_ref_count", n_ref, 0);

    // Timeout with me_done never raised.
    run_job(4'd9, 1'b1, 2, 1000, -1, -1, 1'b0);
    check("D_err_delay", err_rise - start_seen, TO);
    check("D_done_count", n_done, 1);
    check("D_err_sticky", timeout_err, 1);

    // me_done on the last wait cycle: done wins, no error; go clears the error.
    run_job(4'd10, 1'b1, 0, TO - 1, -1, -1, 1'b0);
    check("E_err_cleared", timeout_err, 0);
    check("E_done_latency", done_seen - start_seen, TO);

    // Abort after 50 reference words, then reuse must reload.
    run_job(4'd2, 1'b0, 0, 5, NCUR + 50, -1, 1'b0);
    check("F_start_count", n_start, 0);
    check("F_ref_count", n_ref, 50);
    check("F_done_count", n_done, 0);
    run_job(4'd4, 1'b1, 0, 5, -1, -1, 1'b0);
    check("G_ref_reload", n_ref, NREF);

    // Asynchronous reset during WAIT, then reuse must reload.
    run_job(4'd6, 1'b1, 0, 1000, -1, 5, 1'b0);
    run_job(4'd1, 1'b1, 2, 6, -1, -1, 1'b0);
    check("H_ref_reload_after_reset", n_ref, NREF);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      run_job(4'($urandom), 1'($urandom), $urandom_range(2), $urandom_range(TO + 3, 1),
              ($urandom_range(3) == 0) ? int'($urandom_range(NCUR + NREF - 1)) : -1,
              -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
